// File: rtl/led_pkg.sv
// Shared LED matrix field offsets, geometry and row record for the scan scheduler.
package led_pkg;

    localparam int unsigned RED_LO = 0;
    localparam int unsigned GRN_LO = 8;
    localparam int unsigned BLU_LO = 16;
    localparam int unsigned SEL_LO = 24;
    localparam int unsigned EN_BIT = 27;
    localparam int unsigned ROWS   = 8;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] grn;
    } row_t;

    typedef enum logic {
        ST_BLANK,
        ST_SCAN
    } scan_state_t;

endpackage

// File: rtl/led_row_bank.sv
// Two-bank 8-row pixel register file: one write port, one combinational read port.
module led_row_bank
    import led_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        we,
    input  logic        wbank,
    input  logic [2:0]  wrow,
    input  logic [15:0] wdata,
    input  logic        rbank,
    input  logic [2:0]  rrow,
    output logic [15:0] rdata
);

    row_t mem [2][ROWS];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned r = 0; r < ROWS; r++) begin
                    mem[b][r] <= '0;
                end
            end
        end else if (we) begin
            mem[wbank][wrow] <= row_t'(wdata);
        end
    end

    always_comb begin
        rdata = mem[rbank][rrow];
    end

endmodule

// File: rtl/led_scan_sched.sv
// Double-buffered 8x8 red/green LED matrix scanner with frame-synchronous buffer swap.
module led_scan_sched
    import led_pkg::*;
#(
    parameter int unsigned DIV   = 25000,
    parameter int unsigned BLANK = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        wr_en,
    input  logic [2:0]  wr_row,
    input  logic [7:0]  wr_red,
    input  logic [7:0]  wr_grn,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        frame_start,
    output logic [0:27] led
);

    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0] div_cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    row;
    scan_state_t   state;
    logic          front;
    logic          pending;
    logic          end_row;
    logic          frame_end;
    row_t          front_row;

    led_row_bank u_bank (
        .CLK   (CLK),
        .RST   (RST),
        .we    (wr_en),
        .wbank (~front),
        .wrow  (wr_row),
        .wdata ({wr_red, wr_grn}),
        .rbank (front),
        .rrow  (row),
        .rdata (front_row)
    );

    always_comb begin
        end_row   = (div_cnt == CW'(DIV - 1));
        frame_end = end_row && (row == 3'd7);
        cnt_nxt   = end_row ? '0 : div_cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt             <= '0;
            row                 <= '0;
            state               <= ST_BLANK;
            front               <= 1'b0;
            pending             <= 1'b0;
            swap_ack            <= 1'b0;
            frame_start         <= 1'b0;
            led                 <= '1;
            led[SEL_LO +: 3]    <= '0;
        end else begin
            div_cnt     <= cnt_nxt;
            state       <= (cnt_nxt < CW'(BLANK)) ? ST_BLANK : ST_SCAN;
            frame_start <= frame_end;
            if (end_row) begin
                row <= row + 3'd1;
            end

            // A request landing in the boundary cycle itself is honoured at that boundary.
            if (frame_end) begin
                swap_ack <= pending | swap_req;
                if (pending | swap_req) begin
                    front <= ~front;
                end
                pending <= 1'b0;
            end else begin
                swap_ack <= 1'b0;
                pending  <= pending | swap_req;
            end

            // Pins reflect this cycle's row and state, so they trail them by one clock.
            led[BLU_LO +: 8] <= '1;
            led[EN_BIT]      <= 1'b1;
            led[SEL_LO +: 3] <= row;
            if (state == ST_BLANK) begin
                led[RED_LO +: 8] <= '1;
                led[GRN_LO +: 8] <= '1;
            end else begin
                led[RED_LO +: 8] <= ~front_row.red;
                led[GRN_LO +: 8] <= ~front_row.grn;
            end
        end
    end

endmodule

// File: doc/led_scan_sched.md
LED_SCAN_SCHED -- requirements
Module: led_scan_sched

Interface
REQ-001 Parameter DIV, default 25000: CLK cycles per displayed row; legal range 4..2^20.
REQ-002 Parameter BLANK, default 2: blanking cycles at the start of each row; legal range 1..DIV-2.
REQ-003 CLK  input  1  single clock; all logic on posedge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  write one row of the back buffer this cycle.
REQ-006 wr_row  input  3  row index for the write.
REQ-007 wr_red  input  8  red pixels for the row; 1 = lit.
REQ-008 wr_grn  input  8  green pixels for the row; 1 = lit.
REQ-009 swap_req  input  1  one-cycle request to present the back buffer.
REQ-010 swap_ack  output  1  one-cycle pulse when the buffer swap takes effect.
REQ-011 frame_start  output  1  one-cycle pulse when scanning row 0 begins.
REQ-012 led  output  [0:27]  matrix drive: [0:7] red row, active-low; [8:15] green row, active-low; [16:23] blue, tied to all ones; [24:26] row select; [27] matrix enable.

Function
REQ-013 Two banks SHALL exist, each 8 rows x (8 red + 8 green) bits. One bank is the front (displayed) and the other is the back (written).
REQ-014 A wr_en cycle SHALL write wr_red/wr_grn into back[wr_row] at that clock edge. The front bank SHALL never be written.
REQ-015 A counter div_cnt SHALL run 0..DIV-1. The row counter SHALL advance when div_cnt==DIV-1, wrapping 7->0.
REQ-016 The FSM SHALL have two states: BLANK (div_cnt < BLANK) and SCAN (otherwise). BLANK SHALL be re-entered at every row change.
REQ-017 In BLANK: led[0:15] all ones; led[24:26] = new row.
REQ-018 In SCAN: led[0:7] = ~front[row].red and led[8:15] = ~front[row].grn, both MSB-first, so pixel bit j drives led[7-j] / led[15-j].
REQ-019 led[16:23] SHALL be all ones and led[27] SHALL be 1 at all times after reset.
REQ-020 led SHALL be registered: one cycle latency from the row/state change to the pins.
REQ-021 swap_req SHALL set a sticky pending flag. Further swap_req while pending SHALL be absorbed, with no second swap.
REQ-022 The swap SHALL occur only at the frame boundary, i.e. the edge where row wraps 7->0 (with div_cnt==DIV-1 and row==7). At that edge the front bank index SHALL toggle, pending SHALL clear, and swap_ack SHALL pulse for the following cycle.
REQ-023 A swap_req arriving in the exact boundary cycle SHALL be swapped at that boundary.
REQ-024 A wr_en arriving in the boundary cycle SHALL write the old back bank, which becomes the front.
REQ-025 frame_start SHALL pulse in the first cycle that row==0, independent of any swap.
REQ-026 A wr_row write with wr_en held over consecutive cycles SHALL succeed every cycle; last write wins.

Reset
REQ-027 While RST=1 at an edge: div_cnt=0, row=0, state=BLANK, front index=0, pending=0, swap_ack=0, frame_start=0, and both banks are cleared to 0.
REQ-028 The cycle after reset, led SHALL read: [0:15]=all ones, [16:23]=all ones, [24:26]=0, [27]=1.
REQ-029 RST mid-row or mid-swap-pending SHALL discard the pending swap and restart at row 0 with no swap_ack.

Structure
REQ-030 A shared package led_pkg SHALL hold the LED field offsets (RED_LO=0, GRN_LO=8, BLU_LO=16, SEL_LO=24, EN_BIT=27), ROWS=8, and the row-record type {red[7:0], grn[7:0]}.
REQ-031 One sub-module, led_row_bank, SHALL implement the 2-bank register file. It has one write port (bank, row, data), one read port (bank, row), and synchronous clear.

Verification (DIV=8, BLANK=2)
REQ-032 Reset then idle 64 cycles -> led[24:26] steps 0..7 every 8 cycles; led[0:15] stays all ones; frame_start pulses every 64 cycles.
REQ-033 Write back row 3 with red=8'h81, then swap_req -> swap_ack at frame boundary; then during row 3 SCAN, led[0:7]=8'h7E.
REQ-034 Write row 3 without swap_req -> front is unchanged; led[0:7] stays 8'hFF for the whole frame.
REQ-035 Three swap_req within one frame -> exactly one swap_ack; the front index toggles once.
REQ-036 swap_req and wr_en(row 0, grn=8'h01) in the boundary cycle -> swap occurs; the next row-0 SCAN shows led[8:15]=8'hFE.
REQ-037 RST asserted during row 5 with a swap pending -> row=0 next cycle; no swap_ack; all pixels dark.
